// File: rtl/alu_pkg.sv
// Shared encodings for the bit-serial ALU sequencer: opcodes, FSM states and default width.
package alu_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_MUL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SER    = 2'b01,
    ST_MSHIFT = 2'b10,
    ST_DONE   = 2'b11
  } state_e;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell; the only arithmetic element of the serial ALU.
module full_adder (
  input  logic X,
  input  logic Y,
  input  logic Cin,
  output logic Z,
  output logic Cout
);

  assign Z    = X ^ Y ^ Cin;
  assign Cout = (X & Y) | (X & Cin) | (Y & Cin);

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ADD/SUB/ADC/MUL sequencer time-multiplexing one full_adder, LSB first.
// MUL is shift-and-add: the low accumulator half starts as the multiplier and shifts out.
module serial_alu_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 cout,
  output logic                 zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e               state_r;
  state_e               state_nxt_s;
  op_e                  op_r;
  logic [CW-1:0]        bit_cnt_r;
  logic [CW-1:0]        iter_cnt_r;
  logic                 carry_r;
  logic [WIDTH-1:0]     a_r;
  logic [WIDTH-1:0]     x_sh_r;
  logic [WIDTH-1:0]     y_sh_r;
  logic [WIDTH-1:0]     acc_hi_r;
  logic [WIDTH-1:0]     acc_lo_r;

  logic                 fa_z_s;
  logic                 fa_cout_s;
  logic                 last_bit_s;
  logic                 last_iter_s;
  logic [WIDTH-1:0]     hi_shift_s;
  logic [WIDTH-1:0]     ms_hi_s;
  logic [WIDTH-1:0]     ms_lo_s;

  logic                 busy_nxt_s;
  logic                 done_nxt_s;
  logic                 load_res_s;
  logic [2*WIDTH-1:0]   res_nxt_s;
  logic                 cout_nxt_s;

  logic                 busy_r;
  logic                 done_r;
  logic [2*WIDTH-1:0]   result_r;
  logic                 cout_r;
  logic                 zero_r;

  full_adder u_fa (
    .X    (x_sh_r[0]),
    .Y    (y_sh_r[0]),
    .Cin  (carry_r),
    .Z    (fa_z_s),
    .Cout (fa_cout_s)
  );

  assign last_bit_s  = (bit_cnt_r == CNT_LAST);
  assign last_iter_s = (iter_cnt_r == CNT_LAST);
  assign hi_shift_s  = {fa_z_s, acc_hi_r[WIDTH-1:1]};
  // Multiply shift: {carry, high, low} >> 1.
  assign ms_hi_s     = {carry_r, acc_hi_r[WIDTH-1:1]};
  assign ms_lo_s     = {acc_hi_r[0], acc_lo_r[WIDTH-1:1]};

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_SER;
        else       state_nxt_s = ST_IDLE;
      end
      ST_SER: begin
        if (last_bit_s) state_nxt_s = (op_r == OP_MUL) ? ST_MSHIFT : ST_DONE;
        else            state_nxt_s = ST_SER;
      end
      ST_MSHIFT: begin
        if (last_iter_s) state_nxt_s = ST_DONE;
        else             state_nxt_s = ST_SER;
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output decode; values are registered in the output stage below.
  always_comb begin
    busy_nxt_s = (state_nxt_s != ST_IDLE);
    done_nxt_s = (state_nxt_s == ST_DONE);
    load_res_s = done_nxt_s;
    if (state_r == ST_MSHIFT) begin
      res_nxt_s  = {ms_hi_s, ms_lo_s};
      cout_nxt_s = 1'b0;
    end else begin
      res_nxt_s  = {{WIDTH{1'b0}}, hi_shift_s};
      cout_nxt_s = fa_cout_s;
    end
  end

  // Datapath: operand capture, serial shift registers, counters and carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r       <= OP_ADD;
      bit_cnt_r  <= {CW{1'b0}};
      iter_cnt_r <= {CW{1'b0}};
      carry_r    <= 1'b0;
      a_r        <= {WIDTH{1'b0}};
      x_sh_r     <= {WIDTH{1'b0}};
      y_sh_r     <= {WIDTH{1'b0}};
      acc_hi_r   <= {WIDTH{1'b0}};
      acc_lo_r   <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            op_r       <= op_e'(op);
            a_r        <= a;
            bit_cnt_r  <= {CW{1'b0}};
            iter_cnt_r <= {CW{1'b0}};
            acc_hi_r   <= {WIDTH{1'b0}};
            case (op_e'(op))
              OP_ADD: begin
                carry_r  <= 1'b0;
                x_sh_r   <= a;
                y_sh_r   <= b;
                acc_lo_r <= {WIDTH{1'b0}};
              end
              OP_SUB: begin
                carry_r  <= 1'b1;
                x_sh_r   <= a;
                y_sh_r   <= ~b;
                acc_lo_r <= {WIDTH{1'b0}};
              end
              OP_ADC: begin
                carry_r  <= cin;
                x_sh_r   <= a;
                y_sh_r   <= b;
                acc_lo_r <= {WIDTH{1'b0}};
              end
              OP_MUL: begin
                carry_r  <= 1'b0;
                x_sh_r   <= b[0] ? a : {WIDTH{1'b0}};
                y_sh_r   <= {WIDTH{1'b0}};
                acc_lo_r <= b;
              end
              default: begin
                carry_r  <= 1'b0;
                x_sh_r   <= {WIDTH{1'b0}};
                y_sh_r   <= {WIDTH{1'b0}};
                acc_lo_r <= {WIDTH{1'b0}};
              end
            endcase
          end
        end
        ST_SER: begin
          x_sh_r    <= {1'b0, x_sh_r[WIDTH-1:1]};
          y_sh_r    <= {1'b0, y_sh_r[WIDTH-1:1]};
          acc_hi_r  <= hi_shift_s;
          carry_r   <= fa_cout_s;
          bit_cnt_r <= last_bit_s ? {CW{1'b0}} : bit_cnt_r + CW'(1);
        end
        ST_MSHIFT: begin
          acc_hi_r   <= ms_hi_s;
          acc_lo_r   <= ms_lo_s;
          carry_r    <= 1'b0;
          iter_cnt_r <= last_iter_s ? {CW{1'b0}} : iter_cnt_r + CW'(1);
          // Preload the next pass: gated A against the new high half.
          x_sh_r     <= ms_lo_s[0] ? a_r : {WIDTH{1'b0}};
          y_sh_r     <= ms_hi_s;
        end
        ST_DONE: begin
          carry_r <= carry_r;
        end
        default: begin
          carry_r <= 1'b0;
        end
      endcase
    end
  end

  // Registered outputs; result and flags hold until the next completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= {(2*WIDTH){1'b0}};
      cout_r   <= 1'b0;
      zero_r   <= 1'b1;
    end else begin
      busy_r <= busy_nxt_s;
      done_r <= done_nxt_s;
      if (load_res_s) begin
        result_r <= res_nxt_s;
        cout_r   <= cout_nxt_s;
        zero_r   <= (res_nxt_s == {(2*WIDTH){1'b0}});
      end
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;
  assign cout   = cout_r;
  assign zero   = zero_r;

endmodule
